// File: rtl/jellyvl_synctimer_lock_ctl.sv
// Lock/holdover sequencing controller for the synctimer adjust datapath.
// Measures phase error of each received master timestamp and issues override/normal corrections.
module jellyvl_synctimer_lock_ctl #(
    parameter int TIMER_WIDTH   = 64,
    parameter int ERROR_WIDTH   = 32,
    parameter int LOCK_COUNT    = 4,
    parameter int TIMEOUT_WIDTH = 32
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     enable,
    input  logic [ERROR_WIDTH-1:0]   param_unlock_threshold,
    input  logic [ERROR_WIDTH-1:0]   param_lock_threshold,
    input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
    input  logic [TIMER_WIDTH-1:0]   param_time_comp,
    input  logic [TIMER_WIDTH-1:0]   local_time,
    input  logic [TIMER_WIDTH-1:0]   s_time,
    input  logic                     s_valid,
    output logic [TIMER_WIDTH-1:0]   correct_time,
    output logic                     correct_override,
    output logic                     correct_valid,
    output logic [2:0]               status_state,
    output logic                     status_locked,
    output logic [ERROR_WIDTH-1:0]   status_error
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);

    localparam logic [ERROR_WIDTH-1:0] ERR_MAX = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
    localparam logic [ERROR_WIDTH-1:0] ERR_MIN = {1'b1, {(ERROR_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRACK    = 3'd1,
        ST_LOCKED   = 3'd2,
        ST_HOLDOVER = 3'd3
    } state_t;

    // Clamp a wrapped timer difference (read as signed) into the error range.
    function automatic logic [ERROR_WIDTH-1:0] sat_error(input logic [TIMER_WIDTH-1:0] diff);
        logic [TIMER_WIDTH-ERROR_WIDTH:0] hi;
        hi = diff[TIMER_WIDTH-1:ERROR_WIDTH-1];
        if ((&hi) || (~|hi)) begin
            sat_error = diff[ERROR_WIDTH-1:0];
        end else if (diff[TIMER_WIDTH-1]) begin
            sat_error = ERR_MIN;
        end else begin
            sat_error = ERR_MAX;
        end
    endfunction

    // Magnitude of a signed error; the most-negative value maps to the largest positive one.
    function automatic logic [ERROR_WIDTH-1:0] abs_error(input logic [ERROR_WIDTH-1:0] err);
        if (err == ERR_MIN) begin
            abs_error = ERR_MAX;
        end else if (err[ERROR_WIDTH-1]) begin
            abs_error = ERR_MAX - err + {{(ERROR_WIDTH-1){1'b0}}, 1'b1} - ERR_MIN;
        end else begin
            abs_error = err;
        end
    endfunction

    logic [TIMER_WIDTH-1:0]   w_diff;
    logic [ERROR_WIDTH-1:0]   w_err;
    logic [ERROR_WIDTH-1:0]   w_abs;

    logic                     r_a_valid;
    logic [ERROR_WIDTH-1:0]   r_a_err;
    logic [ERROR_WIDTH-1:0]   r_a_abs;
    logic [TIMER_WIDTH-1:0]   r_a_time;

    logic [TIMEOUT_WIDTH-1:0] r_to_cnt;
    logic [TIMEOUT_WIDTH-1:0] w_to_cnt_next;
    logic                     w_timeout_hit;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_W-1:0]         r_good_cnt;
    logic [CNT_W-1:0]         w_good_next;
    logic [CNT_W-1:0]         w_good_inc;
    logic                     w_issue;
    logic                     w_override;
    logic                     w_big;
    logic                     w_good;

    assign w_diff = s_time - local_time;
    assign w_err  = sat_error(w_diff);
    assign w_abs  = abs_error(w_err);

    // Stage A: capture error, magnitude and compensated timestamp of each accepted sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_valid <= 1'b0;
            r_a_err   <= {ERROR_WIDTH{1'b0}};
            r_a_abs   <= {ERROR_WIDTH{1'b0}};
            r_a_time  <= {TIMER_WIDTH{1'b0}};
        end else if (!enable) begin
            r_a_valid <= 1'b0;
        end else begin
            r_a_valid <= s_valid;
            if (s_valid) begin
                r_a_err  <= w_err;
                r_a_abs  <= w_abs;
                r_a_time <= s_time + param_time_comp;
            end
        end
    end

    // Cycles since the last sample, saturating; the hit uses the value the counter is about to take.
    always_comb begin
        w_to_cnt_next = r_to_cnt;
        w_timeout_hit = 1'b0;
        if (s_valid) begin
            w_to_cnt_next = {TIMEOUT_WIDTH{1'b0}};
        end else if (&r_to_cnt) begin
            w_to_cnt_next = r_to_cnt;
        end else begin
            w_to_cnt_next = r_to_cnt + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
        end
        if (!s_valid && (param_timeout != {TIMEOUT_WIDTH{1'b0}}) && (w_to_cnt_next == param_timeout)) begin
            w_timeout_hit = 1'b1;
        end else begin
            w_timeout_hit = 1'b0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= {TIMEOUT_WIDTH{1'b0}};
        end else if (!enable) begin
            r_to_cnt <= {TIMEOUT_WIDTH{1'b0}};
        end else begin
            r_to_cnt <= w_to_cnt_next;
        end
    end

    assign w_big      = (r_a_abs > param_unlock_threshold);
    assign w_good     = (r_a_abs <= param_lock_threshold);
    assign w_good_inc = r_good_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage B decision; a processed sample always takes priority over a coincident timeout.
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_cnt;
        w_issue      = 1'b0;
        w_override   = 1'b0;
        if (!enable) begin
            w_state_next = ST_IDLE;
            w_good_next  = {CNT_W{1'b0}};
        end else if (r_a_valid) begin
            w_issue = 1'b1;
            case (r_state)
                ST_IDLE: begin
                    w_override   = 1'b1;
                    w_good_next  = {CNT_W{1'b0}};
                    w_state_next = ST_TRACK;
                end
                ST_TRACK: begin
                    if (w_big) begin
                        w_override  = 1'b1;
                        w_good_next = {CNT_W{1'b0}};
                    end else if (w_good) begin
                        w_good_next = w_good_inc;
                        if (w_good_inc >= CNT_W'(LOCK_COUNT)) begin
                            w_state_next = ST_LOCKED;
                        end else begin
                            w_state_next = ST_TRACK;
                        end
                    end else begin
                        w_good_next = {CNT_W{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    if (w_big) begin
                        w_override   = 1'b1;
                        w_good_next  = {CNT_W{1'b0}};
                        w_state_next = ST_TRACK;
                    end else if (!w_good) begin
                        w_good_next  = {CNT_W{1'b0}};
                        w_state_next = ST_TRACK;
                    end else begin
                        w_state_next = ST_LOCKED;
                    end
                end
                ST_HOLDOVER: begin
                    w_override   = w_big;
                    w_good_next  = {CNT_W{1'b0}};
                    w_state_next = ST_TRACK;
                end
                default: begin
                    w_issue      = 1'b0;
                    w_good_next  = {CNT_W{1'b0}};
                    w_state_next = ST_IDLE;
                end
            endcase
        end else if (w_timeout_hit && ((r_state == ST_TRACK) || (r_state == ST_LOCKED))) begin
            w_state_next = ST_HOLDOVER;
            w_good_next  = {CNT_W{1'b0}};
        end else begin
            w_state_next = r_state;
            w_good_next  = r_good_cnt;
        end
    end

    // FSM state and good-sample counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_good_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state    <= w_state_next;
            r_good_cnt <= w_good_next;
        end
    end

    // Registered correction command and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            correct_valid    <= 1'b0;
            correct_override <= 1'b0;
            correct_time     <= {TIMER_WIDTH{1'b0}};
            status_locked    <= 1'b0;
            status_error     <= {ERROR_WIDTH{1'b0}};
        end else begin
            correct_valid    <= w_issue;
            correct_override <= w_issue & w_override;
            status_locked    <= (w_state_next == ST_LOCKED);
            if (w_issue) begin
                correct_time <= r_a_time;
                status_error <= r_a_err;
            end
        end
    end

    assign status_state = r_state;

endmodule

// File: tb/tb_jellyvl_synctimer_lock_ctl.sv
// Randomized scoreboard bench for jellyvl_synctimer_lock_ctl against a per-sample rule model.
module tb_jellyvl_synctimer_lock_ctl;

    localparam int LC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] unlock_thr;
    logic [31:0] lock_thr;
    logic [31:0] timeout;
    logic [63:0] time_comp;
    logic [63:0] local_time;
    logic [63:0] s_time;
    logic        s_valid;
    logic [63:0] correct_time;
    logic        correct_override;
    logic        correct_valid;
    logic [2:0]  status_state;
    logic        status_locked;
    logic [31:0] status_error;

    jellyvl_synctimer_lock_ctl #(
        .TIMER_WIDTH(64), .ERROR_WIDTH(32), .LOCK_COUNT(LC), .TIMEOUT_WIDTH(32)
    ) dut (
        .reset(reset), .clk(clk), .enable(enable),
        .param_unlock_threshold(unlock_thr), .param_lock_threshold(lock_thr),
        .param_timeout(timeout), .param_time_comp(time_comp),
        .local_time(local_time), .s_time(s_time), .s_valid(s_valid),
        .correct_time(correct_time), .correct_override(correct_override),
        .correct_valid(correct_valid), .status_state(status_state),
        .status_locked(status_locked), .status_error(status_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] t;
        logic        ov;
        logic [2:0]  st;
        logic [31:0] err;
        logic        lk;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          m_state = 0;
    int          m_good = 0;
    longint      m_idle = 0;
    bit          m_last = 1'b0;
    logic [31:0] m_last_err = 32'd0;
    logic [31:0] m_prev_err = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one sample to the rule model and queue the correction it must produce.
    function automatic void model_sample(input logic [63:0] st, input logic [63:0] lt);
        logic [63:0] dd;
        longint d, e, a;
        bit big, good, ov;
        exp_t x;
        dd = st - lt;
        d = $signed(dd);
        if (d > 64'sd2147483647) e = 64'sd2147483647;
        else if (d < -64'sd2147483648) e = -64'sd2147483648;
        else e = d;
        a = (e < 0) ? -e : e;
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        big  = a > longint'({32'd0, unlock_thr});
        good = a <= longint'({32'd0, lock_thr});
        ov = 1'b0;
        case (m_state)
            0: begin ov = 1'b1; m_good = 0; m_state = 1; end
            1: begin
                if (big) begin ov = 1'b1; m_good = 0; end
                else if (good) begin m_good++; if (m_good >= LC) m_state = 2; end
                else m_good = 0;
            end
            2: begin
                if (big) begin ov = 1'b1; m_good = 0; m_state = 1; end
                else if (!good) begin m_good = 0; m_state = 1; end
            end
            default: begin ov = big; m_good = 0; m_state = 1; end
        endcase
        x.t   = st + time_comp;
        x.ov  = ov;
        x.st  = 3'(m_state);
        x.err = e[31:0];
        x.lk  = (m_state == 2);
        m_prev_err = m_last_err;
        m_last_err = e[31:0];
        q.push_back(x);
    endfunction

    // One clock cycle of stimulus, mirrored into the model.
    task automatic drive(input bit v, input logic [63:0] st, input logic [63:0] lt, input bit en);
        @(negedge clk);
        enable = en; s_valid = v; s_time = st; local_time = lt;
        if (!en) begin
            if (m_last) begin
                void'(q.pop_back());
                m_last_err = m_prev_err;
            end
            m_last = 1'b0; m_state = 0; m_good = 0; m_idle = 0;
        end else if (v) begin
            m_idle = 0;
            model_sample(st, lt);
            m_last = 1'b1;
        end else begin
            m_last = 1'b0;
            m_idle++;
            if (timeout != 32'd0 && m_idle == longint'({32'd0, timeout}) && (m_state == 1 || m_state == 2)) begin
                m_state = 3; m_good = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 64'd0, 64'd0, 1'b1);
    endtask

    // Issue a sample and stop at the cycle its correction pulse is visible.
    task automatic sample_wait(input logic [63:0] st, input logic [63:0] lt);
        drive(1'b1, st, lt, 1'b1);
        idle(2);
    endtask

    // Scoreboard monitor: pops one expectation per correction pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && correct_valid) begin
            if (q.size() == 0) begin
                errors++; checks++;
                $display("FAIL unexpected_pulse: got correct_valid=1 expected no pulse at %0t", $time);
            end else begin
                e = q.pop_front();
                check("corr_time", correct_time, e.t);
                check("corr_override", {63'd0, correct_override}, {63'd0, e.ov});
                check("state", {61'd0, status_state}, {61'd0, e.st});
                check("error", {32'd0, status_error}, {32'd0, e.err});
                check("locked", {63'd0, status_locked}, {63'd0, e.lk});
            end
        end
    end

    initial begin
        logic [63:0] lt, st, big40;
        longint d;
        int r, gap, k;
        reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_time = 64'd0; local_time = 64'd0;
        unlock_thr = 32'd1000; lock_thr = 32'd10; timeout = 32'd0; time_comp = 64'h10;
        repeat (3) @(negedge clk);
        check("rst_valid", {63'd0, correct_valid}, 64'd0);
        check("rst_time", correct_time, 64'd0);
        check("rst_state", {61'd0, status_state}, 64'd0);
        check("rst_error", {32'd0, status_error}, 64'd0);
        check("rst_locked", {63'd0, status_locked}, 64'd0);
        reset = 1'b0;

        // first sample: latency and override
        drive(1'b1, 64'd1000, 64'd900, 1'b1);
        idle(1);
        check("lat_n1", {63'd0, correct_valid}, 64'd0);
        idle(1);
        check("lat_n2", {63'd0, correct_valid}, 64'd1);
        check("t1_override", {63'd0, correct_override}, 64'd1);
        check("t1_time", correct_time, 64'd1016);
        check("t1_error", {32'd0, status_error}, 64'd100);
        check("t1_state", {61'd0, status_state}, 64'd1);

        // four good samples lock
        for (int i = 0; i < 4; i++) begin
            sample_wait(64'd5005 + 64'(i * 100), 64'd5000 + 64'(i * 100));
            check("t2_override", {63'd0, correct_override}, 64'd0);
        end
        check("t2_locked", {63'd0, status_locked}, 64'd1);
        check("t2_state", {61'd0, status_state}, 64'd2);

        // leaving lock
        sample_wait(64'd7050, 64'd7000);
        check("t3_state", {61'd0, status_state}, 64'd1);
        check("t3_locked", {63'd0, status_locked}, 64'd0);
        check("t3_override", {63'd0, correct_override}, 64'd0);
        sample_wait(64'd13000, 64'd8000);
        check("t3_big_override", {63'd0, correct_override}, 64'd1);

        // holdover after exactly 100 idle cycles
        timeout = 32'd100;
        drive(1'b1, 64'd9003, 64'd9000, 1'b1);
        idle(100);
        check("t4_pre_timeout", {61'd0, status_state}, 64'd1);
        idle(1);
        check("t4_holdover", {61'd0, status_state}, 64'd3);
        sample_wait(64'd10003, 64'd10000);
        check("t4_override", {63'd0, correct_override}, 64'd0);
        check("t4_state", {61'd0, status_state}, 64'd1);

        // negative saturation, then back-to-back samples
        big40 = 64'd1 << 40;
        sample_wait(64'd5, big40 + 64'd5);
        check("t5_error", {32'd0, status_error}, {32'd0, 32'h8000_0000});
        check("t5_override", {63'd0, correct_override}, 64'd1);
        drive(1'b1, 64'd200, 64'd100, 1'b1);
        drive(1'b1, 64'd300, 64'd303, 1'b1);
        drive(1'b1, 64'd400, 64'd399, 1'b1);
        idle(4);

        // randomized blocks
        for (int b = 0; b < 6; b++) begin
            idle(3);
            lock_thr   = $urandom_range(0, 200);
            unlock_thr = $urandom_range(0, 3000);
            timeout    = (b == 2) ? 32'd0 : $urandom_range(2, 40);
            time_comp  = {$urandom, $urandom};
            for (int n = 0; n < 80; n++) begin
                lt = {$urandom, $urandom};
                k = $urandom_range(0, 2);
                if (k == 0) d = longint'($urandom_range(0, 2 * lock_thr + 10)) - longint'(lock_thr) - 5;
                else if (k == 1) d = longint'($urandom_range(0, 8000)) - 4000;
                else d = ($urandom_range(0, 1) ? 64'sd1 : -64'sd1) * ((64'sd1 <<< 35) + longint'($urandom));
                st = lt + 64'(d);
                drive(1'b1, st, lt, 1'b1);
                r = $urandom_range(0, 9);
                gap = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 4) : $urandom_range(20, 60);
                idle(gap);
            end
        end
        idle(4);

        // enable drop with sample in flight
        drive(1'b1, 64'd777, 64'd700, 1'b1);
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        check("t6_en_state", {61'd0, status_state}, 64'd0);
        check("t6_en_locked", {63'd0, status_locked}, 64'd0);
        check("t6_en_error_hold", {32'd0, status_error}, {32'd0, m_last_err});
        idle(3);

        // async reset with sample in flight
        drive(1'b1, 64'd500, 64'd400, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1; s_valid = 1'b0;
        #1;
        check("t6_rst_valid", {63'd0, correct_valid}, 64'd0);
        check("t6_rst_override", {63'd0, correct_override}, 64'd0);
        check("t6_rst_time", correct_time, 64'd0);
        check("t6_rst_state", {61'd0, status_state}, 64'd0);
        check("t6_rst_error", {32'd0, status_error}, 64'd0);
        q.delete();
        m_state = 0; m_good = 0; m_idle = 0; m_last = 1'b0; m_last_err = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        check("t6_no_pulse", {63'd0, correct_valid}, 64'd0);
        sample_wait(64'd2000, 64'd1990);
        check("t6_recover_override", {63'd0, correct_override}, 64'd1);
        idle(3);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
